cpu_ififo: RTL and testbench

//   Instruction FIFO between the moxie fetch stage and decode. Accepts 32-bit big-endian

---
 rtl/cpu_ififo_pkg.sv | 33 +++
 rtl/cpu_ififo_lendec.sv | 19 +
 rtl/cpu_ififo.sv | 128 ++++++++++++
 tb/tb_cpu_ififo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ififo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ififo_pkg
// Description : Shared constants and helpers for the moxie instruction FIFO:
//               default depth, the list of long-form opcode bytes and the
//               head-halfword length function.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ififo_pkg;

    localparam int c_depth_default = 16;

    // High bytes of opcodes that carry a trailing 32-bit immediate
    localparam int c_num_long_ops = 17;
    localparam logic [7:0] c_long_ops [c_num_long_ops] = '{
        8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
        8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39
    };

    // Instruction length in halfwords for a given head halfword: 3 or 1
    function automatic logic [1:0] is_long(input logic [15:0] h);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < c_num_long_ops; i++) begin
            if (h[15:8] == c_long_ops[i]) begin
                hit = 1'b1;
            end
        end
        return (hit && !h[15]) ? 2'd3 : 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ififo_lendec.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ififo_lendec
// Description : Combinational instruction length decoder for the head
//               halfword of the instruction FIFO (1 or 3 halfwords).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ififo_lendec
    import cpu_ififo_pkg::*;
(
    input  logic [15:0] head,
    output logic [1:0]  len
);

    // Length follows purely from the opcode's high byte
    assign len = is_long(head);

endmodule
`default_nettype wire

// File: rtl/cpu_ififo.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ififo
// Description : Instruction FIFO between fetch and decode. Accepts 32-bit
//               big-endian words, stores halfwords, and pops one complete
//               instruction (opcode plus optional 32-bit operand) per read.
//               Optional macro IFIFO_ZERO_OPERAND_EN: short pops clear
//               operand_o instead of holding it.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ififo
    import cpu_ififo_pkg::*;
#(
    parameter int DEPTH = c_depth_default
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_en_i,
    input  logic        read_en_i,
    input  logic [31:0] data_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [15:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [c_ptr_w-1:0] w_rd_ptr1;
    logic [c_ptr_w-1:0] w_rd_ptr2;
    logic [c_ptr_w-1:0] w_wr_ptr1;
    logic [15:0]        w_head;
    logic [1:0]         w_len;
    logic [c_cnt_w-1:0] w_len_cnt;
    logic               w_full;
    logic               w_wr_acc;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count_next;

    assign w_rd_ptr1 = r_rd_ptr + c_ptr_w'(1);
    assign w_rd_ptr2 = r_rd_ptr + c_ptr_w'(2);
    assign w_wr_ptr1 = r_wr_ptr + c_ptr_w'(1);
    assign w_head    = r_mem[r_rd_ptr];

    cpu_ififo_lendec u_lendec (
        .head (w_head),
        .len  (w_len)
    );

    assign w_len_cnt = c_cnt_w'(w_len);

    // Fewer than two free slots means a whole word cannot be taken
    assign w_full   = (r_count > c_cnt_w'(DEPTH - 2));
    assign w_wr_acc = write_en_i && !w_full;
    // Only pop when every halfword of the head instruction is present
    assign w_pop    = read_en_i && (r_count >= w_len_cnt);

    assign empty_o = (r_count == '0);
    assign full_o  = w_full;

    // Next occupancy from pre-edge count, accepted write and pop length
    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc) begin
            w_count_next = w_count_next + c_cnt_w'(2);
        end
        if (w_pop) begin
            w_count_next = w_count_next - w_len_cnt;
        end
    end

    // Halfword storage: earlier halfword (upper bits) goes first
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr]  <= data_i[31:16];
            r_mem[w_wr_ptr1] <= data_i[15:0];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(2);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_len);
            end
            r_count <= w_count_next;
        end
    end

    // Registered instruction outputs, valid for one cycle per pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcode_o  <= '0;
            operand_o <= '0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= w_pop;
            if (w_pop) begin
                opcode_o <= w_head;
                if (w_len == 2'd3) begin
                    operand_o <= {r_mem[w_rd_ptr1], r_mem[w_rd_ptr2]};
                end else begin
`ifdef IFIFO_ZERO_OPERAND_EN
                    operand_o <= 32'h0;
`else
                    operand_o <= operand_o;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ififo.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ififo
// Description : Directed self-checking bench for cpu_ififo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ififo;

    localparam int c_depth = 16;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic        read_en;
    logic [31:0] data;
    logic [15:0] opcode;
    logic [31:0] operand;
    logic        valid;
    logic        empty;
    logic        full;

    int checks   = 0;
    int failures = 0;

    cpu_ififo #(.DEPTH(c_depth)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .write_en_i (write_en),
        .read_en_i  (read_en),
        .data_i     (data),
        .opcode_o   (opcode),
        .operand_o  (operand),
        .valid_o    (valid),
        .empty_o    (empty),
        .full_o     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        write_en = 1'b1;
        data     = w;
        tick();
        write_en = 1'b0;
    endtask

    logic [31:0] short_operand;
    int          nrx;
    int          nwr;

    initial begin
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data     = '0;
`ifdef IFIFO_ZERO_OPERAND_EN
        short_operand = 32'h0;
`else
        short_operand = 32'h12345678;
`endif
        repeat (2) tick();

        // 1. reset state
        check("rst_empty",   48'(empty),   48'(1));
        check("rst_full",    48'(full),    48'(0));
        check("rst_valid",   48'(valid),   48'(0));
        check("rst_opcode",  48'(opcode),  48'(0));
        check("rst_operand", 48'(operand), 48'(0));
        rst = 1'b0;
        tick();

        // 2. long then short
        push(32'h01201234);
        push(32'h56780F00);
        read_en = 1'b1;
        tick();
        check("ls_valid0",   48'(valid),   48'(1));
        check("ls_opcode0",  48'(opcode),  48'(16'h0120));
        check("ls_operand0", 48'(operand), 48'(32'h12345678));
        tick();
        check("ls_valid1",   48'(valid),   48'(1));
        check("ls_opcode1",  48'(opcode),  48'(16'h0F00));
        check("ls_operand1", 48'(operand), 48'(short_operand));
        tick();
        check("ls_valid2",   48'(valid),   48'(0));
        check("ls_empty",    48'(empty),   48'(1));
        check("ls_hold",     48'(opcode),  48'(16'h0F00));

        // 3. partial long is never popped
        push(32'h0120ABCD);
        check("pl_valid0", 48'(valid), 48'(0));
        tick();
        check("pl_valid1", 48'(valid), 48'(0));
        check("pl_empty",  48'(empty), 48'(0));
        push(32'h00110F00);
        check("pl_valid2", 48'(valid), 48'(0));
        tick();
        check("pl_valid3",   48'(valid),   48'(1));
        check("pl_opcode",   48'(opcode),  48'(16'h0120));
        check("pl_operand",  48'(operand), 48'(32'hABCD0011));
        tick();
        check("pl_opcode2",  48'(opcode),  48'(16'h0F00));
        tick();
        check("pl_done",     48'(valid),   48'(0));
        check("pl_empty2",   48'(empty),   48'(1));
        read_en = 1'b0;

        // 4. fill, overflow drop, drain in order
        for (int k = 0; k < c_depth / 2; k++) begin
            if (k == c_depth / 2 - 1) begin
                check("fill_notfull", 48'(full), 48'(0));
            end
            push({16'h0F00 + 16'(2 * k), 16'h0F01 + 16'(2 * k)});
        end
        check("fill_full", 48'(full), 48'(1));
        push(32'hDEADBEEF);
        check("fill_full2", 48'(full), 48'(1));
        read_en = 1'b1;
        for (int k = 0; k < c_depth; k++) begin
            tick();
            check($sformatf("drain_valid%0d", k), 48'(valid), 48'(1));
            check($sformatf("drain_op%0d", k), 48'(opcode), 48'(16'h0F00 + 16'(k)));
        end
        tick();
        check("drain_done",  48'(valid), 48'(0));
        check("drain_empty", 48'(empty), 48'(1));

        // 5. concurrent write/read across pointer wrap
        nrx = 0;
        nwr = 0;
        for (int cyc = 0; cyc < 200 && nrx < 2 * c_depth; cyc++) begin
            if (nwr < c_depth && !full) begin
                write_en = 1'b1;
                data     = {16'h0F00 + 16'(2 * nwr), 16'h0F01 + 16'(2 * nwr)};
                nwr++;
            end else begin
                write_en = 1'b0;
            end
            tick();
            if (valid) begin
                check($sformatf("wrap_op%0d", nrx), 48'(opcode), 48'(16'h0F00 + 16'(nrx)));
                nrx++;
            end
        end
        write_en = 1'b0;
        check("wrap_count", 48'(nrx), 48'(2 * c_depth));
        tick();
        check("wrap_empty", 48'(empty), 48'(1));
        read_en = 1'b0;

        // 6. reset mid-stream
        push(32'h0F010F02);
        push(32'h0F030F04);
        push(32'h0F050F06);
        check("mr_notempty", 48'(empty), 48'(0));
        rst = 1'b1;
        #1;
        check("mr_empty", 48'(empty), 48'(1));
        check("mr_valid", 48'(valid), 48'(0));
        @(negedge clk);
        rst = 1'b0;
        push(32'h0F000F01);
        read_en = 1'b1;
        tick();
        check("mr_op0", 48'(opcode), 48'(16'h0F00));
        check("mr_v0",  48'(valid),  48'(1));
        tick();
        check("mr_op1", 48'(opcode), 48'(16'h0F01));
        tick();
        check("mr_end", 48'(valid),  48'(0));
        read_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
